// File: rtl/clip_pipe.sv
// clip_pipe
// Two-stage round/shift/saturate pipeline for CHANNELS signed fixed-point
// samples per beat. Each sample is rounded (optionally), arithmetic-shifted
// down by SHIFT bits and saturated to an unsigned OUT_W-bit value. It also
// keeps running counts of how many samples clipped high and low.
//
// Ports:
//   Clock       system clock, rising edge
//   Resetn      asynchronous active-low reset
//   in_valid    input beat valid
//   in_ready    block can accept a beat this cycle
//   in_data     CHANNELS signed IN_W-bit samples, channel 0 in the LSBs
//   out_valid   output beat valid
//   out_ready   downstream accepts the beat
//   out_data    CHANNELS unsigned OUT_W-bit clipped samples
//   out_sat     per-channel clip flag, aligned with out_data
//   clr_stats   synchronous clear of both clip counters
//   sat_hi_cnt  saturating count of samples clipped to full scale
//   sat_lo_cnt  saturating count of samples clipped to zero
module clip_pipe #(
  parameter int IN_W     = 32,
  parameter int OUT_W    = 8,
  parameter int CHANNELS = 3,
  parameter int SHIFT    = 16,
  parameter int ROUND    = 1,
  parameter int CNT_W    = 16
) (
  input  logic                      Clock,
  input  logic                      Resetn,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*IN_W-1:0]  in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*OUT_W-1:0] out_data,
  output logic [CHANNELS-1:0]       out_sat,
  input  logic                      clr_stats,
  output logic [CNT_W-1:0]          sat_hi_cnt,
  output logic [CNT_W-1:0]          sat_lo_cnt
);

  // Rounding constant; the separate shift amount keeps SHIFT=0 from
  // producing a negative shift count even in the unused branch.
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [IN_W:0] RND =
    (ROUND != 0 && SHIFT > 0) ? ((IN_W+1)'(1) << RSH) : '0;

  logic                           va;
  logic [CHANNELS-1:0][IN_W:0]    a_q;
  logic [CHANNELS-1:0][IN_W:0]    a_next;
  logic [CHANNELS-1:0][OUT_W-1:0] b_next;
  logic [CHANNELS-1:0]            hi_flag;
  logic [CHANNELS-1:0]            lo_flag;
  logic                           adv_b;
  logic                           load_b;
  logic [CNT_W:0]                 hi_n;
  logic [CNT_W:0]                 lo_n;
  logic [CNT_W:0]                 hi_sum;
  logic [CNT_W:0]                 lo_sum;

  // Stage B moves whenever its slot is empty or being drained; stage A can
  // take a new beat when it is empty or is handing its beat on to B.
  assign adv_b    = !out_valid || out_ready;
  assign in_ready = !va || adv_b;
  assign load_b   = adv_b && va;

  // Round and shift in IN_W+1 bits so adding the rounding constant to the
  // most positive input cannot wrap negative.
  always_comb begin
    a_next = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      a_next[c] = ($signed({in_data[c*IN_W+IN_W-1], in_data[c*IN_W +: IN_W]})
                   + $signed(RND)) >>> SHIFT;
    end
  end

  // Saturate the shifted value: negative goes to zero, anything with bits
  // above OUT_W goes to full scale. Also tally clips for the counters.
  always_comb begin
    hi_flag = '0;
    lo_flag = '0;
    b_next  = '0;
    hi_n    = '0;
    lo_n    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      lo_flag[c] = a_q[c][IN_W];
      hi_flag[c] = !a_q[c][IN_W] && (|a_q[c][IN_W-1:OUT_W]);
      if (lo_flag[c])
        b_next[c] = '0;
      else if (hi_flag[c])
        b_next[c] = '1;
      else
        b_next[c] = a_q[c][OUT_W-1:0];
      hi_n = hi_n + {{CNT_W{1'b0}}, hi_flag[c]};
      lo_n = lo_n + {{CNT_W{1'b0}}, lo_flag[c]};
    end
    hi_sum = {1'b0, sat_hi_cnt} + hi_n;
    lo_sum = {1'b0, sat_lo_cnt} + lo_n;
  end

  // Stage A register: holds the round+shift result.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      va  <= 1'b0;
      a_q <= '0;
    end else if (in_ready) begin
      va <= in_valid;
      if (in_valid)
        a_q <= a_next;
    end
  end

  // Stage B register: the output register, held while stalled.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= '0;
    end else if (adv_b) begin
      out_valid <= va;
      if (va) begin
        out_data <= b_next;
        out_sat  <= hi_flag | lo_flag;
      end
    end
  end

  // Clip counters advance as a beat loads into stage B and stick at their
  // maximum; a clear on the same edge takes priority over the count.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sat_hi_cnt <= '0;
      sat_lo_cnt <= '0;
    end else if (clr_stats) begin
      sat_hi_cnt <= '0;
      sat_lo_cnt <= '0;
    end else if (load_b) begin
      sat_hi_cnt <= hi_sum[CNT_W] ? '1 : hi_sum[CNT_W-1:0];
      sat_lo_cnt <= lo_sum[CNT_W] ? '1 : lo_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_clip_pipe.sv
// tb_clip_pipe
// Scoreboard bench for clip_pipe. The main instance uses default parameters;
// a second instance is built with ROUND=0 and CNT_W=4 for truncation and
// counter-saturation cases. Drivers push expected beats when a handshake is
// seen; independent monitors pop and compare when outputs transfer.
module tb_clip_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        Resetn;

  logic        in_valid, in_ready, out_valid, out_ready, clr_stats;
  logic [95:0] in_data;
  logic [23:0] out_data;
  logic [2:0]  out_sat;
  logic [15:0] sat_hi_cnt, sat_lo_cnt;

  logic        x_in_valid, x_in_ready, x_out_valid, x_out_ready, x_clr_stats;
  logic [95:0] x_in_data;
  logic [23:0] x_out_data;
  logic [2:0]  x_out_sat;
  logic [3:0]  x_sat_hi_cnt, x_sat_lo_cnt;

  clip_pipe dut (
    .Clock(clk), .Resetn(Resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .clr_stats(clr_stats),
    .sat_hi_cnt(sat_hi_cnt), .sat_lo_cnt(sat_lo_cnt)
  );

  clip_pipe #(.ROUND(0), .CNT_W(4)) dut_aux (
    .Clock(clk), .Resetn(Resetn),
    .in_valid(x_in_valid), .in_ready(x_in_ready), .in_data(x_in_data),
    .out_valid(x_out_valid), .out_ready(x_out_ready), .out_data(x_out_data),
    .out_sat(x_out_sat), .clr_stats(x_clr_stats),
    .sat_hi_cnt(x_sat_hi_cnt), .sat_lo_cnt(x_sat_lo_cnt)
  );

  typedef struct packed {
    logic [23:0] data;
    logic [2:0]  sat;
  } beat_t;

  beat_t sbMain[$];
  beat_t sbAux[$];
  beat_t em;
  beat_t ea;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  lastPushCyc = 0;
  int  lastPopCyc = 0;
  bit  tpMode = 0;
  int  tpCount = 0;
  int  tpFirstPop = 0;
  int  tpLastPop = 0;
  int  tpFirstPush = 0;
  bit  bpCheck = 0;
  bit  bpDone = 0;
  bit  prevHeld = 0;
  logic [26:0] prevBeat = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Present one beat and wait (bounded) until it is accepted. Entered and
  // left just after a rising edge.
  task automatic applyStimulus(input bit aux, input logic [95:0] data,
                               input logic [23:0] expData, input logic [2:0] expSat);
    bit accepted = 0;
    beat_t b;
    b.data = expData;
    b.sat  = expSat;
    if (aux) begin
      x_in_valid = 1'b1;
      x_in_data  = data;
    end else begin
      in_valid = 1'b1;
      in_data  = data;
    end
    for (int n = 0; n < 200 && !accepted; n++) begin
      @(negedge clk);
      if (aux && x_in_ready === 1'b1) begin
        sbAux.push_back(b);
        accepted = 1;
      end else if (!aux && in_ready === 1'b1) begin
        sbMain.push_back(b);
        lastPushCyc = cyc;
        accepted = 1;
      end
      @(posedge clk);
      #1;
    end
    if (aux) x_in_valid = 1'b0;
    else     in_valid   = 1'b0;
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got no in_ready, expected acceptance");
    end
  endtask

  task automatic waitDrain(input bit aux);
    bit done = 0;
    for (int n = 0; n < 500 && !done; n++) begin
      @(negedge clk);
      if (aux ? (sbAux.size() == 0) : (sbMain.size() == 0)) done = 1;
    end
    @(posedge clk);
    #1;
    checkOutput(aux ? "drain_aux" : "drain_main", 32'(done), 32'd1);
  endtask

  // Main monitor: scoreboard compare on transfer, plus hold stability.
  initial forever begin
    @(negedge clk);
    if (prevHeld && out_valid)
      checkOutput("hold_stable", {5'b0, out_sat, out_data}, {5'b0, prevBeat});
    if (out_valid && out_ready) begin
      if (sbMain.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_out: got beat 0x%0h, expected none", out_data);
      end else begin
        em = sbMain.pop_front();
        checkOutput("main_beat", {5'b0, out_sat, out_data}, {5'b0, em.sat, em.data});
      end
      lastPopCyc = cyc;
      if (tpMode) begin
        if (tpCount == 0) tpFirstPop = cyc;
        tpLastPop = cyc;
        tpCount++;
      end
    end
    prevHeld = out_valid && !out_ready;
    prevBeat = {out_sat, out_data};
  end

  // Auxiliary instance monitor.
  initial forever begin
    @(negedge clk);
    if (x_out_valid && x_out_ready) begin
      if (sbAux.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_aux: got beat 0x%0h, expected none", x_out_data);
      end else begin
        ea = sbAux.pop_front();
        checkOutput("aux_beat", {5'b0, x_out_sat, x_out_data}, {5'b0, ea.sat, ea.data});
      end
    end
  end

  // in_ready may only drop when both stages hold a beat and B is stalled.
  initial forever begin
    @(posedge clk);
    #3;
    if (bpCheck)
      checkOutput("in_ready_bp", 32'(in_ready),
                  32'(!(sbMain.size() == 2 && !out_ready)));
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Resetn = 1'b0;
    in_valid = 0; in_data = '0; out_ready = 1'b1; clr_stats = 0;
    x_in_valid = 0; x_in_data = '0; x_out_ready = 1'b1; x_clr_stats = 0;
    repeat (3) @(posedge clk);
    #1;
    Resetn = 1'b1;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_data", {5'b0, out_sat, out_data}, 32'd0);
    checkOutput("rst_cnts", {sat_hi_cnt, sat_lo_cnt}, 32'd0);
    checkOutput("rst_aux_ready", 32'(x_in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Single beat, mixed clips.
    applyStimulus(0, {32'h007F_7FFF, 32'hFFFF_0000, 32'h00FF_8000},
                  {8'h7F, 8'h00, 8'hFF}, 3'b011);
    waitDrain(0);
    checkOutput("latency", 32'(lastPopCyc - lastPushCyc), 32'd2);
    checkOutput("cnt_hi_1", 32'(sat_hi_cnt), 32'd1);
    checkOutput("cnt_lo_1", 32'(sat_lo_cnt), 32'd1);

    // Boundaries: exact zero, exact full scale, max positive, most negative.
    applyStimulus(0, {32'h7FFF_FFFF, 32'h00FF_7FFF, 32'hFFFF_8000},
                  {8'hFF, 8'hFF, 8'h00}, 3'b100);
    applyStimulus(0, {32'h0001_0000, 32'h0000_0000, 32'h8000_0000},
                  {8'h01, 8'h00, 8'h00}, 3'b001);
    waitDrain(0);
    checkOutput("cnt_hi_2", 32'(sat_hi_cnt), 32'd2);
    checkOutput("cnt_lo_2", 32'(sat_lo_cnt), 32'd2);

    // Truncating build, then counter saturation and clear priority.
    applyStimulus(1, {32'hFFFF_FFFF, 32'h0001_FFFF, 32'h0000_FFFF},
                  {8'h00, 8'h01, 8'h00}, 3'b100);
    waitDrain(1);
    checkOutput("aux_lo_1", 32'(x_sat_lo_cnt), 32'd1);
    checkOutput("aux_hi_0", 32'(x_sat_hi_cnt), 32'd0);
    for (int i = 0; i < 6; i++)
      applyStimulus(1, {3{32'h7FFF_FFFF}}, {3{8'hFF}}, 3'b111);
    waitDrain(1);
    checkOutput("aux_hi_sat", 32'(x_sat_hi_cnt), 32'd15);
    checkOutput("aux_lo_keep", 32'(x_sat_lo_cnt), 32'd1);
    applyStimulus(1, {3{32'h7FFF_FFFF}}, {3{8'hFF}}, 3'b111);
    x_clr_stats = 1'b1;
    @(posedge clk);
    #1;
    x_clr_stats = 1'b0;
    waitDrain(1);
    checkOutput("aux_hi_clr", 32'(x_sat_hi_cnt), 32'd0);
    checkOutput("aux_lo_clr", 32'(x_sat_lo_cnt), 32'd0);

    // Backpressure with pseudo-random out_ready.
    bpCheck = 1;
    bpDone  = 0;
    fork
      begin
        for (int i = 0; i < 10; i++)
          applyStimulus(0, {16'(3*i+3), 16'h0, 16'(3*i+2), 16'h0, 16'(3*i+1), 16'h0},
                        {8'(3*i+3), 8'(3*i+2), 8'(3*i+1)}, 3'b000);
        waitDrain(0);
        bpDone = 1;
      end
      begin
        while (!bpDone) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bpCheck = 0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Full-rate streaming.
    tpMode = 1;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(0, {16'(i+2), 16'h0, 16'(i+1), 16'h0, 16'(i), 16'h0},
                    {8'(i+2), 8'(i+1), 8'(i)}, 3'b000);
      if (i == 0) tpFirstPush = lastPushCyc;
    end
    waitDrain(0);
    tpMode = 0;
    checkOutput("tp_count", 32'(tpCount), 32'd100);
    checkOutput("tp_span", 32'(tpLastPop - tpFirstPop), 32'd99);
    checkOutput("tp_first", 32'(tpFirstPop - tpFirstPush), 32'd2);
    checkOutput("cnt_hi_tp", 32'(sat_hi_cnt), 32'd2);

    // Reset with both stages full.
    out_ready = 1'b0;
    applyStimulus(0, {3{32'h7FFF_FFFF}}, {3{8'hFF}}, 3'b111);
    applyStimulus(0, {3{32'h0000_0000}}, {3{8'h00}}, 3'b000);
    #2;
    Resetn = 1'b0;
    sbMain.delete();
    #1;
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_data", {5'b0, out_sat, out_data}, 32'd0);
    checkOutput("mid_rst_cnts", {sat_hi_cnt, sat_lo_cnt}, 32'd0);
    @(posedge clk);
    #1;
    Resetn = 1'b1;
    out_ready = 1'b1;
    #1;
    checkOutput("post_rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    applyStimulus(0, {32'h0005_0000, 32'h0004_0000, 32'h0003_0000},
                  {8'h05, 8'h04, 8'h03}, 3'b000);
    waitDrain(0);
    checkOutput("post_rst_latency", 32'(lastPopCyc - lastPushCyc), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
